// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Top-level parameters default to the constants here.
package dmem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_MAX_WAIT   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arbState_e;

  // Width needed to count 0..maxWait inclusive.
  function automatic int waitWidth(input int maxWait);
    return (maxWait < 1) ? 1 : $clog2(maxWait + 1);
  endfunction

endpackage

// File: rtl/dmem_burst_ctr.sv
// Loadable burst address / beat counter. The address wraps modulo 2^ADDR_WIDTH;
// lastBeat flags the final beat of the loaded burst.
module dmem_burst_ctr #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic [LEN_WIDTH-1:0]  loadLen,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  lastBeat
);

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  beatsLeft_r;

  // Address and remaining-beat registers; load wins over step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_r      <= {ADDR_WIDTH{1'b0}};
      beatsLeft_r <= {LEN_WIDTH{1'b0}};
    end else if (load) begin
      addr_r      <= loadAddr;
      beatsLeft_r <= loadLen;
    end else if (step) begin
      addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      // Hold at zero after the final beat rather than wrapping.
      if (beatsLeft_r != {LEN_WIDTH{1'b0}}) begin
        beatsLeft_r <= beatsLeft_r - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        beatsLeft_r <= beatsLeft_r;
      end
    end else begin
      addr_r      <= addr_r;
      beatsLeft_r <= beatsLeft_r;
    end
  end

  assign addr     = addr_r;
  assign lastBeat = (beatsLeft_r == {LEN_WIDTH{1'b0}});

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and a burst DMA.
// A wait counter forces a DMA beat, stalling the core, after MAX_WAIT losses in a row.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_mem_read,
  input  logic                  core_mem_write,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [LEN_WIDTH-1:0]  dma_len,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_gnt,
  output logic                  dma_done,
  output logic                  dma_busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int WaitW = waitWidth(MAX_WAIT);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MAX_WAIT);

  arbState_e             state_r, stateNext_s;
  logic [WaitW-1:0]      waitCnt_r, waitNext_s;
  logic                  dmaWe_r;
  logic                  done_r, doneNext_s;
  logic                  coreAct_s, coreServ_s, beat_s, load_s;
  logic [ADDR_WIDTH-1:0] burstAddr_s;
  logic                  lastBeat_s;

  assign coreAct_s = core_mem_read | core_mem_write;

  dmem_burst_ctr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) uBurstCtr (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .step    (beat_s),
    .loadAddr(dma_addr),
    .loadLen (dma_len),
    .addr    (burstAddr_s),
    .lastBeat(lastBeat_s)
  );

  // State, wait counter, latched direction and the done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      waitCnt_r <= {WaitW{1'b0}};
      dmaWe_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      waitCnt_r <= waitNext_s;
      dmaWe_r   <= load_s ? dma_we : dmaWe_r;
      done_r    <= doneNext_s;
    end
  end

  // Next-state and arbitration decision.
  always_comb begin
    stateNext_s = state_r;
    waitNext_s  = waitCnt_r;
    doneNext_s  = 1'b0;
    load_s      = 1'b0;
    coreServ_s  = 1'b0;
    beat_s      = 1'b0;
    core_stall  = 1'b0;
    case (state_r)
      IDLE: begin
        coreServ_s = coreAct_s;
        if (dma_req) begin
          load_s      = 1'b1;
          waitNext_s  = {WaitW{1'b0}};
          stateNext_s = BURST;
        end else begin
          stateNext_s = IDLE;
        end
      end
      BURST: begin
        if (!coreAct_s) begin
          beat_s     = 1'b1;
          waitNext_s = {WaitW{1'b0}};
        end else if (waitCnt_r < WaitLimit) begin
          coreServ_s = 1'b1;
          waitNext_s = waitCnt_r + {{(WaitW-1){1'b0}}, 1'b1};
        end else begin
          beat_s     = 1'b1;
          core_stall = 1'b1;
          waitNext_s = {WaitW{1'b0}};
        end
        if (beat_s && lastBeat_s) begin
          stateNext_s = IDLE;
          doneNext_s  = 1'b1;
        end else begin
          stateNext_s = BURST;
        end
      end
      default: begin
        stateNext_s = IDLE;
        waitNext_s  = {WaitW{1'b0}};
      end
    endcase
  end

  // RAM port and read-data steering for whichever side owns this cycle.
  always_comb begin
    ram_addr   = {ADDR_WIDTH{1'b0}};
    ram_wdata  = {DATA_WIDTH{1'b0}};
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    core_rdata = {DATA_WIDTH{1'b0}};
    dma_rdata  = {DATA_WIDTH{1'b0}};
    if (coreServ_s) begin
      ram_addr   = core_addr;
      ram_wdata  = core_wdata;
      ram_we     = core_mem_write;
      ram_re     = core_mem_read;
      core_rdata = ram_rdata;
    end else if (beat_s) begin
      ram_addr  = burstAddr_s;
      ram_wdata = dma_wdata;
      ram_we    = dmaWe_r;
      ram_re    = ~dmaWe_r;
      dma_rdata = ram_rdata;
    end else begin
      ram_addr = {ADDR_WIDTH{1'b0}};
    end
  end

  assign dma_gnt  = beat_s;
  assign dma_done = done_r;
  assign dma_busy = (state_r == BURST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read RAM model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_mem_read, core_mem_write;
  logic [7:0]  core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        core_stall;
  logic        dma_req, dma_we;
  logic [7:0]  dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_gnt, dma_done, dma_busy;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  logic [31:0] mem [0:255];
  int          checks = 0;
  int          failures = 0;
  int          grants;

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_busy(dma_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    core_mem_read  = 1'b0;
    core_mem_write = 1'b0;
    core_addr      = 8'h00;
    core_wdata     = 32'h0;
    dma_req        = 1'b0;
    dma_we         = 1'b0;
    dma_addr       = 8'h00;
    dma_len        = 4'h0;
    dma_wdata      = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    idleInputs();
    reset = 1'b0;

    // 1: reset with random inputs
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      core_mem_read  = 1'($urandom_range(1, 0));
      core_mem_write = 1'b0;
      core_addr      = 8'($urandom);
      dma_req        = 1'($urandom_range(1, 0));
      dma_addr       = 8'($urandom);
      @(negedge clk);
      checkEq("rst_busy", {31'h0, dma_busy}, 32'h0);
      checkEq("rst_done", {31'h0, dma_done}, 32'h0);
      checkEq("rst_gnt", {31'h0, dma_gnt}, 32'h0);
      checkEq("rst_stall", {31'h0, core_stall}, 32'h0);
      nextCycle();
    end
    idleInputs();
    reset = 1'b1;
    @(negedge clk);
    checkEq("idle_ram_we", {31'h0, ram_we}, 32'h0);
    checkEq("idle_ram_addr", {24'h0, ram_addr}, 32'h0);
    nextCycle();

    // 2: core store then load
    core_mem_write = 1'b1; core_addr = 8'h10; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checkEq("st_we", {31'h0, ram_we}, 32'h1);
    checkEq("st_addr", {24'h0, ram_addr}, 32'h10);
    checkEq("st_stall", {31'h0, core_stall}, 32'h0);
    nextCycle();
    core_mem_write = 1'b0; core_mem_read = 1'b1;
    @(negedge clk);
    checkEq("ld_data", core_rdata, 32'hDEADBEEF);
    checkEq("ld_re", {31'h0, ram_re}, 32'h1);
    checkEq("ld_stall", {31'h0, core_stall}, 32'h0);
    nextCycle();
    idleInputs();

    // 3: DMA write burst FE..01 with core idle
    dma_req = 1'b1; dma_addr = 8'hFE; dma_len = 4'd3; dma_we = 1'b1;
    @(negedge clk);
    checkEq("wb_accept_gnt", {31'h0, dma_gnt}, 32'h0);
    nextCycle();
    dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dma_wdata = 32'hA0000000 + 32'(i);
      @(negedge clk);
      checkEq("wb_gnt", {31'h0, dma_gnt}, 32'h1);
      checkEq("wb_addr", {24'h0, ram_addr}, {24'h0, 8'(8'hFE + 8'(i))});
      checkEq("wb_we", {31'h0, ram_we}, 32'h1);
      checkEq("wb_busy", {31'h0, dma_busy}, 32'h1);
      checkEq("wb_done_early", {31'h0, dma_done}, 32'h0);
      nextCycle();
    end
    dma_wdata = 32'h0;
    @(negedge clk);
    checkEq("wb_done", {31'h0, dma_done}, 32'h1);
    checkEq("wb_gnt_after", {31'h0, dma_gnt}, 32'h0);
    checkEq("wb_busy_after", {31'h0, dma_busy}, 32'h0);
    nextCycle();
    @(negedge clk);
    checkEq("wb_done_once", {31'h0, dma_done}, 32'h0);
    checkEq("wb_mem_00", mem[8'h00], 32'hA0000002);
    checkEq("wb_mem_fe", mem[8'hFE], 32'hA0000000);
    nextCycle();

    // 4: starvation - core reads every cycle, DMA read of 0xFF, len 0
    core_mem_read = 1'b1; core_addr = 8'h10;
    dma_req = 1'b1; dma_addr = 8'hFF; dma_len = 4'd0; dma_we = 1'b0;
    @(negedge clk);
    checkEq("sv_accept_rdata", core_rdata, 32'hDEADBEEF);
    nextCycle();
    dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkEq("sv_core_stall", {31'h0, core_stall}, 32'h0);
      checkEq("sv_core_gnt", {31'h0, dma_gnt}, 32'h0);
      checkEq("sv_core_rdata", core_rdata, 32'hDEADBEEF);
      nextCycle();
    end
    @(negedge clk);
    checkEq("sv_forced_stall", {31'h0, core_stall}, 32'h1);
    checkEq("sv_forced_gnt", {31'h0, dma_gnt}, 32'h1);
    checkEq("sv_forced_rdata", dma_rdata, 32'hA0000001);
    checkEq("sv_forced_we", {31'h0, ram_we}, 32'h0);
    checkEq("sv_forced_core_rdata", core_rdata, 32'h0);
    nextCycle();
    @(negedge clk);
    checkEq("sv_done", {31'h0, dma_done}, 32'h1);
    checkEq("sv_stall_release", {31'h0, core_stall}, 32'h0);
    checkEq("sv_rdata_back", core_rdata, 32'hDEADBEEF);
    nextCycle();
    idleInputs();

    // 5: reset in the middle of an 8-beat write burst
    dma_req = 1'b1; dma_addr = 8'h40; dma_len = 4'd7; dma_we = 1'b1; dma_wdata = 32'h55;
    nextCycle();
    dma_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkEq("mr_gnt", {31'h0, dma_gnt}, 32'h1);
      checkEq("mr_addr", {24'h0, ram_addr}, {24'h0, 8'(8'h40 + 8'(i))});
      nextCycle();
    end
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkEq("mr_busy", {31'h0, dma_busy}, 32'h0);
      checkEq("mr_no_done", {31'h0, dma_done}, 32'h0);
      checkEq("mr_gnt_off", {31'h0, dma_gnt}, 32'h0);
      nextCycle();
    end
    checkEq("mr_mem_kept", mem[8'h41], 32'h55);
    dma_req = 1'b1; dma_addr = 8'h80; dma_len = 4'd0; dma_wdata = 32'h77;
    nextCycle();
    dma_req = 1'b0;
    @(negedge clk);
    checkEq("mr_new_gnt", {31'h0, dma_gnt}, 32'h1);
    checkEq("mr_new_addr", {24'h0, ram_addr}, 32'h80);
    nextCycle();
    @(negedge clk);
    checkEq("mr_new_done", {31'h0, dma_done}, 32'h1);
    nextCycle();
    idleInputs();

    // 6: core store and DMA request together; late request ignored
    core_mem_write = 1'b1; core_addr = 8'h20; core_wdata = 32'h1234;
    dma_req = 1'b1; dma_addr = 8'h30; dma_len = 4'd1; dma_we = 1'b0;
    @(negedge clk);
    checkEq("sim_stall", {31'h0, core_stall}, 32'h0);
    checkEq("sim_we", {31'h0, ram_we}, 32'h1);
    checkEq("sim_addr", {24'h0, ram_addr}, 32'h20);
    checkEq("sim_gnt", {31'h0, dma_gnt}, 32'h0);
    nextCycle();
    idleInputs();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      // Second request mid-burst should be dropped.
      dma_req  = (i == 0) ? 1'b1 : 1'b0;
      dma_addr = 8'h90; dma_len = 4'd5; dma_we = 1'b1;
      @(negedge clk);
      if (i == 0) checkEq("sim_first_beat_addr", {24'h0, ram_addr}, 32'h30);
      if (i == 1) checkEq("sim_second_beat_addr", {24'h0, ram_addr}, 32'h31);
      if (i == 2) checkEq("sim_done", {31'h0, dma_done}, 32'h1);
      if (dma_gnt) grants++;
      nextCycle();
    end
    idleInputs();
    checkEq("sim_grant_count", 32'(grants), 32'd2);
    checkEq("sim_busy_end", {31'h0, dma_busy}, 32'h0);

    // Illegal read+write: write wins, read strobe still asserted
    core_mem_read = 1'b1; core_mem_write = 1'b1; core_addr = 8'h20; core_wdata = 32'h4321;
    @(negedge clk);
    checkEq("rw_we", {31'h0, ram_we}, 32'h1);
    checkEq("rw_re", {31'h0, ram_re}, 32'h1);
    checkEq("rw_rdata_old", core_rdata, 32'h1234);
    nextCycle();
    idleInputs();
    checkEq("rw_mem", mem[8'h20], 32'h4321);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters:
  - the pipeline MEM stage (the core);
  - a burst requester (DMA / program-data loader).
- The core has priority by default. A wait counter guarantees DMA forward progress by stalling the core when the limit is hit.
- Sits between the EX/MEM pipe register outputs and the DataMemory instance. It drives the RAM address, write data and enables.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- ADDR_WIDTH, 8, word-address width of the RAM.
- LEN_WIDTH, 4, width of the burst-length field; burst length is dma_len+1 beats.
- MAX_WAIT, 4, number of cycles the core may win against a pending DMA beat before the DMA is forced.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- core_mem_read  in  1  MEM-stage load
- core_mem_write  in  1  MEM-stage store
- core_addr  in  ADDR_WIDTH  core word address
- core_wdata  in  DATA_WIDTH  store data
- core_rdata  out  DATA_WIDTH  load data, same cycle as the access
- core_stall  out  1  core access not serviced this cycle; hold the pipeline
- dma_req  in  1  one-cycle request pulse; dma_addr, dma_len and dma_we are valid with it
- dma_we  in  1  1 = write burst, 0 = read burst
- dma_addr  in  ADDR_WIDTH  burst start address
- dma_len  in  LEN_WIDTH  beats minus one
- dma_wdata  in  DATA_WIDTH  write data; must be valid while dma_gnt=1
- dma_rdata  out  DATA_WIDTH  read data, valid while dma_gnt=1
- dma_gnt  out  1  a DMA beat executes this cycle
- dma_done  out  1  one-cycle pulse after the final beat
- dma_busy  out  1  burst in progress
- ram_addr  out  ADDR_WIDTH  to RAM
- ram_wdata  out  DATA_WIDTH  to RAM
- ram_we  out  1  to RAM
- ram_re  out  1  to RAM
- ram_rdata  in  DATA_WIDTH  RAM read data (combinational read)

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to IDLE; beat counter, address and wait counter clear to 0.
  - dma_done and dma_busy are 0.
  - Combinational outputs follow from IDLE, so with no core access every output is 0.
- core_act = core_mem_read | core_mem_write.
- IDLE state:
  - The core is serviced whenever core_act=1: ram_addr=core_addr, ram_wdata=core_wdata, ram_we=core_mem_write, ram_re=core_mem_read, core_stall=0.
  - dma_req=1 latches addr, len, we; clears wait_cnt; next state is BURST.
  - Latching happens regardless of core_act. No beat is issued in the accept cycle.
- BURST state, evaluated each cycle:
  - core_act=0: a DMA beat executes; dma_gnt=1, RAM is driven from the DMA path (ram_we=latched we, ram_re=~we); wait_cnt is cleared.
  - core_act=1 and wait_cnt<MAX_WAIT: the core is serviced; dma_gnt=0; wait_cnt increments.
  - core_act=1 and wait_cnt==MAX_WAIT: the DMA beat executes; core_stall=1; ram_we is never driven by the core; wait_cnt is cleared.
  - After each beat the address increments modulo 2^ADDR_WIDTH (wraps 0xFF→0x00) and the beat counter decrements.
  - After the final beat: next state is IDLE and dma_done=1 for exactly one cycle (the first IDLE cycle).
- dma_req is ignored while dma_busy=1 (BURST); no queuing.
- core_rdata = ram_rdata whenever the core is serviced. dma_rdata = ram_rdata whenever dma_gnt=1. Otherwise both are 0.
- core_mem_read and core_mem_write both 1 is illegal. If it occurs, the write is performed and ram_re is also asserted.
- Reset mid-burst: the burst is abandoned and no dma_done is produced. Beats already written stay in RAM.
- Latency:
  - Core: zero-cycle when not stalled; stall is at most 1 consecutive cycle per DMA beat.
  - DMA: first beat no earlier than 1 cycle after dma_req; a full burst completes within (len+1)*(MAX_WAIT+1) cycles.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, BURST};
  - localparam widths derived from ADDR_WIDTH, LEN_WIDTH and MAX_WAIT (wait_cnt width = clog2(MAX_WAIT+1)).
- One natural sub-module, dmem_burst_ctr: a loadable address/beat counter with wrap, a decrement and a last-beat flag.
- The FSM, wait counter and port muxing stay in the top.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with random inputs → dma_busy=0, dma_done=0, dma_gnt=0; core_stall=0 throughout.
2. Core only:
   - Store 0xDEADBEEF to 0x10 → ram_we=1, ram_addr=0x10.
   - Next cycle, load 0x10 → core_rdata=0xDEADBEEF; core_stall never asserted.
3. DMA write burst with core idle: dma_addr=0xFE, dma_len=3, dma_we=1 →
   - dma_gnt high for 4 consecutive cycles starting 1 cycle after the request;
   - ram_addr = 0xFE, 0xFF, 0x00, 0x01 (wrap);
   - dma_done pulses 1 cycle after the last beat.
4. Starvation: core accesses every cycle; DMA read with len=0 →
   - the core is serviced for 4 cycles;
   - on the 5th cycle core_stall=1, dma_gnt=1 and dma_rdata = RAM contents;
   - next cycle dma_done=1 and core_stall=0.
5. Reset mid-burst: len=7, assert reset=0 after 2 beats →
   - dma_busy=0 next cycle, no dma_done;
   - a subsequent request with len=0 completes normally.
6. Simultaneous events: dma_req and a core store in the same IDLE cycle →
   - the store completes with core_stall=0;
   - the burst is latched and its first beat is in the next cycle;
   - a second dma_req during BURST is ignored (exactly len+1 grants).
